pcileech_tlp_tx_arb: RTL
========================

# pcileech_tlp_tx_arb

Packet-granular two-port arbiter that shares the single PCIe core transmit stream (s_axis_tx) between two TLP sources: port 0, the host TLP stream from the FT601 FIFOs, and port 1, an on-FPGA TLP generator. It sits between those sources and the PCIe controller's 34-bit TLP receive interface. Whole TLPs are passed through unmodified and never interleaved, with round-robin fairness between the ports. Per-port packet counters and a sticky mid-packet stall flag are provided for status reporting.

## Interface
- TIMEOUT_CYCLES, 1024 — stall threshold in cycles; valid range 2..65535.
- CNT_WIDTH, 16 — width of each packet counter.

- user_clk  in  1  — PCIe user clock; all logic is on this clock.
- user_reset  in  1  — asynchronous, active-high reset.
- rx0_data  in  34  — port 0 beat: [31:0] dword, [32] last, [33] sideband (passed through).
- rx0_valid  in  1  — port 0 beat valid.
- rx0_ready  out  1  — port 0 beat accepted.
- rx1_data  in  34  — port 1 beat, same format as rx0_data.
- rx1_valid  in  1  — port 1 beat valid.
- rx1_ready  out  1  — port 1 beat accepted.
- tx_data  out  34  — beat to the PCIe controller TLP input.
- tx_valid  out  1  — tx beat valid.
- tx_ready  in  1  — controller ready (s_axis_tx_tready).
- grant  out  2  — registered grant: 01 = port 0, 10 = port 1, 00 = idle.
- stall_err  out  1  — sticky mid-packet stall flag.
- pkt_cnt0  out  CNT_WIDTH  — packets completed from port 0.
- pkt_cnt1  out  CNT_WIDTH  — packets completed from port 1.

## Operation
- **States:** IDLE and BUSY.
- **IDLE:**
  - tx_valid=0, rx0_ready=0, rx1_ready=0, grant=00.
  - If any rxN_valid=1, register the winner into grant and go to BUSY on the next edge.
- **Round-robin:** register last_port, reset value 1.
  - Only one port valid: that port wins.
  - Both ports valid: the port != last_port wins.
  - last_port is updated to the winner when the grant is registered.
- **BUSY, datapath (combinational pass-through from the granted port N):**
  - tx_data = rxN_data (all 34 bits).
  - tx_valid = rxN_valid.
  - rxN_ready = tx_ready.
  - The non-granted ready is held 0.
- **BUSY, packet end:** an accepted beat (valid && ready) with data[32]=1 ends the packet.
  - The granted port's pkt_cnt is incremented.
  - The next state is IDLE.
- **Idle tx_data:** tx_data = 34'h0 whenever tx_valid=0 due to IDLE state.
- **Grant lock:** the grant is held until the last beat of the packet regardless of the other port's requests. There is no packet-length limit and no abort.
- **Stall timer** (width $clog2(TIMEOUT_CYCLES+1)):
  - Active in BUSY only.
  - Increments each cycle the granted rxN_valid=0.
  - Clears to 0 on any cycle the granted valid=1, and on entry to IDLE.
  - When it reaches TIMEOUT_CYCLES-1 while still incrementing, stall_err is set.
  - stall_err stays 1 until user_reset; the timer saturates.
  - The packet continues normally once valid returns.
- **Back-pressure:** tx_ready=0 with valid=1 is not a stall; the timer is cleared.
- **Counters:** wrap modulo 2^CNT_WIDTH, so all-ones + 1 = 0.

## Timing
- **Reset values:** state=IDLE, grant=00, last_port=1, stall_err=0, pkt_cnt0=pkt_cnt1=0, tx_valid=0, tx_data=0, rx0_ready=rx1_ready=0.
- **Reset mid-packet:** all registers clear immediately and asynchronously; tx_valid drops at once. The truncated TLP is the system reset's responsibility.
- **Arbitration latency:** a request seen in IDLE at edge k gives grant and tx_valid visible after edge k+1. The first beat transfers no earlier than cycle k+1.
- **Inter-packet bubble:** exactly one IDLE cycle after each last beat, including back-to-back packets from the same port.
- **Pass-through:** zero-cycle combinational path for data, valid and ready in BUSY.
- **Packet counter timing:** pkt_cnt updates on the edge that accepts the last beat.
- **Single-beat packet** (last=1 on the first beat): BUSY lasts one accepted beat.
- **Simultaneous events:** the last beat accepted in the same cycle the other port raises valid gives IDLE then a grant to the other port. The ordering is BUSY(last), IDLE (register grant), BUSY.

## Test plan
- **Port 0 alone:** 3-beat TLP (last on beat 3), tx_ready=1 → grant=01 one cycle after valid; 3 beats out in order with bit 32 only on beat 3; pkt_cnt0=1; one bubble cycle; grant=00.
- **Both ports from reset:** each has a 4-beat TLP queued → port 0 served first; port 1 granted after the 1-cycle bubble; no interleave. A repeated dual request then serves port 0, alternating.
- **Port 1 mid-packet while port 0 busy:** port 1 raises valid during port 0's packet → rx1_ready stays 0 until port 0's last beat is accepted; grant=10 two edges later.
- **Stall with TIMEOUT_CYCLES=8:** port 0 drops valid for 8 cycles mid-packet → stall_err=1 after the 8th idle cycle and stays 1 after the packet completes. A 7-cycle gap → stall_err stays 0. tx_ready=0 for 100 cycles with valid=1 → stall_err stays 0.
- **Counter wrap with CNT_WIDTH=4:** 17 single-beat packets on port 1 → pkt_cnt1=1.
- **Reset mid-packet:** user_reset asserted asynchronously mid-beat → tx_valid, ready and grant drop the same instant; counters are 0; after release, the first tie is won by port 0.

Source files
------------

// File: rtl/pcileech_tlp_tx_arb.sv
// Packet-granular round-robin arbiter sharing the PCIe core TLP transmit stream
// between the host TLP path (port 0) and an on-FPGA TLP generator (port 1).
module pcileech_tlp_tx_arb #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 user_clk,
  input  logic                 user_reset,
  input  logic [33:0]          rx0_data,
  input  logic                 rx0_valid,
  output logic                 rx0_ready,
  input  logic [33:0]          rx1_data,
  input  logic                 rx1_valid,
  output logic                 rx1_ready,
  output logic [33:0]          tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [1:0]           grant,
  output logic                 stall_err,
  output logic [CNT_WIDTH-1:0] pkt_cnt0,
  output logic [CNT_WIDTH-1:0] pkt_cnt1
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_SET = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e               state_q, state_d;
  logic [1:0]           grant_q, grant_d;
  logic                 last_port_q, last_port_d;
  logic                 stall_err_q, stall_err_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [CNT_WIDTH-1:0] pkt_cnt0_q, pkt_cnt0_d;
  logic [CNT_WIDTH-1:0] pkt_cnt1_q, pkt_cnt1_d;

  logic g_valid;
  logic g_last;
  logic accept_last;
  logic winner;

  // Zero-latency pass-through from the granted port; idle drives zeros.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    tx_data   = '0;
    tx_valid  = 1'b0;
    rx0_ready = 1'b0;
    rx1_ready = 1'b0;
    if (state_q == S_BUSY) begin
      if (grant_q[1]) begin
        tx_data   = rx1_data;
        tx_valid  = rx1_valid;
        rx1_ready = tx_ready;
      end else begin
        tx_data   = rx0_data;
        tx_valid  = rx0_valid;
        rx0_ready = tx_ready;
      end
    end
  end

  assign g_valid     = grant_q[1] ? rx1_valid    : rx0_valid;
  assign g_last      = grant_q[1] ? rx1_data[32] : rx0_data[32];
  assign accept_last = (state_q == S_BUSY) && g_valid && tx_ready && g_last;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_port_d = last_port_q;
    stall_err_d = stall_err_q;
    timer_d     = '0;
    pkt_cnt0_d  = pkt_cnt0_q;
    pkt_cnt1_d  = pkt_cnt1_q;
    winner      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx0_valid || rx1_valid) begin
          // On a tie the port that did not win last time goes next.
          winner      = (rx0_valid && rx1_valid) ? ~last_port_q : rx1_valid;
          grant_d     = winner ? 2'b10 : 2'b01;
          last_port_d = winner;
          state_d     = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!g_valid) begin
          timer_d = (timer_q < TIMER_MAX) ? timer_q + 1'b1 : timer_q;
          if (timer_q >= TIMER_SET) stall_err_d = 1'b1;
        end
        if (accept_last) begin
          state_d = S_IDLE;
          grant_d = 2'b00;
          if (grant_q[1]) pkt_cnt1_d = pkt_cnt1_q + 1'b1;
          else            pkt_cnt0_d = pkt_cnt0_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      state_q     <= S_IDLE;
      grant_q     <= 2'b00;
      last_port_q <= 1'b1;
      stall_err_q <= 1'b0;
      timer_q     <= '0;
      pkt_cnt0_q  <= '0;
      pkt_cnt1_q  <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_port_q <= last_port_d;
      stall_err_q <= stall_err_d;
      timer_q     <= timer_d;
      pkt_cnt0_q  <= pkt_cnt0_d;
      pkt_cnt1_q  <= pkt_cnt1_d;
    end
  end

  assign grant     = grant_q;
  assign stall_err = stall_err_q;
  assign pkt_cnt0  = pkt_cnt0_q;
  assign pkt_cnt1  = pkt_cnt1_q;

endmodule
